// File: rtl/level_pkg.sv
// Level-code definitions shared by the level sensor conditioner and the reservoir
// flow controller.
package level_pkg;

   // Thermometer codes: bit n set means water is above sensor n.
   typedef enum logic [2:0] {
      LVL_NONE = 3'b000,
      LVL_S0   = 3'b001,
      LVL_S1   = 3'b011,
      LVL_S2   = 3'b111
   } level_t;

   typedef enum logic {
      ST_MONITOR = 1'b0,
      ST_FAULT   = 1'b1
   } fault_state_t;

   function automatic logic level_is_legal(input logic [2:0] code);
      return code inside {LVL_NONE, LVL_S0, LVL_S1, LVL_S2};
   endfunction

endpackage

// File: rtl/level_sensor_conditioner_bit_debouncer.sv
// Single sensor contact: 2-flop synchronizer followed by a mismatch-run debouncer.
module bit_debouncer
   import level_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Counter tops out at CNT_MAX and is cleared on the flip, so it never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync2 == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         stable <= sync2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/level_sensor_conditioner.sv
// Conditions three level-sensor contacts into a legal thermometer code, holding the
// last good level through transients and latching a fault on persistent inconsistency.
module level_sensor_conditioner
   import level_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned FAULT_CYCLES    = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] raw_s,
   input  logic       fault_clr,
   output logic [2:0] s,
   output logic       changed,
   output logic       fault
);

   localparam int unsigned FW = $clog2(FAULT_CYCLES + 1);
   localparam logic [FW-1:0] FAULT_MAX = FW'(FAULT_CYCLES);

   logic [2:0]    db;
   logic          legal;
   logic [FW-1:0] fcnt;
   fault_state_t  state_q;
   fault_state_t  state_d;
   logic [2:0]    s_d;

   for (genvar i = 0; i < 3; i++) begin : g_bit
      bit_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (raw_s[i]),
         .stable(db[i])
      );
   end

   assign legal = level_is_legal(db);

   always_ff @(posedge clk) begin
      if (reset || legal) begin
         fcnt <= '0;
      end else if (fcnt != FAULT_MAX) begin
         fcnt <= fcnt + FW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s;
      unique case (state_q)
         ST_MONITOR: begin
            if (fcnt == FAULT_MAX) begin
               state_d = ST_FAULT;
               s_d     = LVL_NONE;
            end else if (legal) begin
               s_d = db;
            end
         end
         ST_FAULT: begin
            if (fault_clr && legal) begin
               state_d = ST_MONITOR;
               s_d     = db;
            end
         end
         default: begin
            state_d = ST_MONITOR;
            s_d     = LVL_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_MONITOR;
         s       <= '0;
         changed <= 1'b0;
      end else begin
         state_q <= state_d;
         s       <= s_d;
         changed <= (s_d != s);
      end
   end

   assign fault = (state_q == ST_FAULT);

   a_fault_forces_none : assert property (@(posedge clk) disable iff (reset)
      fault |-> (s == LVL_NONE));

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Self-checking bench for level_sensor_conditioner against a history-window reference model.
module tb_level_sensor_conditioner;

   localparam int unsigned DEB = 4;
   localparam int unsigned FLT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] raw_s = 3'b000;
   logic       fault_clr = 1'b0;
   logic [2:0] s;
   logic       changed;
   logic       fault;

   int total = 0;
   int bad = 0;

   // Reference model: raw samples newest-first; stable bit flips once DEB+1
   // consecutive synchronized samples all disagree with it.
   logic [2:0] hist[$];
   logic [2:0] m_stable = 3'b000;
   logic [2:0] m_s = 3'b000;
   logic       m_fault = 1'b0;
   logic       m_changed = 1'b0;
   int         ill_run = 0;

   level_sensor_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .FAULT_CYCLES   (FLT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .raw_s    (raw_s),
      .fault_clr(fault_clr),
      .s        (s),
      .changed  (changed),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   function automatic bit code_ok(input logic [2:0] c);
      return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
   endfunction

   task automatic model_edge();
      logic [2:0] nstable;
      logic [2:0] h;
      logic [2:0] prev_s;
      bit         all_diff;
      if (reset) begin
         hist.delete();
         for (int k = 0; k < DEB + 2; k++) hist.push_back(3'b000);
         m_stable  = 3'b000;
         m_s       = 3'b000;
         m_fault   = 1'b0;
         m_changed = 1'b0;
         ill_run   = 0;
      end else begin
         nstable = m_stable;
         for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= DEB + 1; k++) begin
               h = hist[k];
               if (h[b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) nstable[b] = ~m_stable[b];
         end
         prev_s = m_s;
         if (m_fault) begin
            if (fault_clr && code_ok(m_stable)) begin
               m_fault = 1'b0;
               m_s     = m_stable;
            end
         end else if (ill_run >= FLT) begin
            m_fault = 1'b1;
            m_s     = 3'b000;
         end else if (code_ok(m_stable)) begin
            m_s = m_stable;
         end
         m_changed = (m_s != prev_s);
         ill_run   = code_ok(m_stable) ? 0 : ((ill_run > FLT) ? ill_run : ill_run + 1);
         m_stable  = nstable;
         hist.push_front(raw_s);
         void'(hist.pop_back());
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      raw_s = 3'b111;
      fault_clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if ({s, fault, changed} !== 5'b000_0_0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d: s=%b fault=%b changed=%b, want 000 0 0", i, s, fault, changed);
         end
      end
      reset = 1'b0;
      fault_clr = 1'b0;
      cycle();
      total++;
      if ({s, fault, changed} !== 5'b000_0_0) begin
         bad++;
         $display("FAIL reset_first: s=%b fault=%b changed=%b, want 000 0 0", s, fault, changed);
      end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      reset = 1'b1;
      raw_s = 3'b000;
      cycle();
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         raw_s = (i < 3) ? 3'b001 : 3'b000;
         cycle();
         if (changed === 1'b1) pulses++;
         total++;
         if ({s, fault, changed} !== {m_s, m_fault, m_changed}) begin
            bad++;
            $display("FAIL glitch_model cyc=%0d: s=%b fault=%b changed=%b, want %b %b %b", i, s, fault, changed, m_s, m_fault, m_changed);
         end
         total++;
         if (s !== 3'b000) begin
            bad++;
            $display("FAIL glitch_s cyc=%0d: s=%b, want 000", i, s);
         end
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL glitch_changed: pulses=%0d, want 0", pulses);
      end
   endtask

   task automatic test_step();
      int first = -1;
      int pulses = 0;
      raw_s = 3'b001;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (s === 3'b001 && first < 0) first = i;
         if (changed === 1'b1) pulses++;
         total++;
         if ({s, fault, changed} !== {m_s, m_fault, m_changed}) begin
            bad++;
            $display("FAIL step_model cyc=%0d: s=%b fault=%b changed=%b, want %b %b %b", i, s, fault, changed, m_s, m_fault, m_changed);
         end
      end
      total++;
      if (first != DEB + 3) begin
         bad++;
         $display("FAIL step_latency: edges=%0d, want %0d", first, DEB + 3);
      end
      total++;
      if (pulses != 1 || fault !== 1'b0) begin
         bad++;
         $display("FAIL step_pulse: pulses=%0d fault=%b, want 1 0", pulses, fault);
      end
   endtask

   task automatic test_fault();
      int pulses = 0;
      bit seen = 1'b0;
      raw_s = 3'b010;
      for (int i = 0; i < 60 && !seen; i++) begin
         cycle();
         if (changed === 1'b1) pulses++;
         total++;
         if ({s, fault, changed} !== {m_s, m_fault, m_changed}) begin
            bad++;
            $display("FAIL fault_model cyc=%0d: s=%b fault=%b changed=%b, want %b %b %b", i, s, fault, changed, m_s, m_fault, m_changed);
         end
         if (fault === 1'b1) seen = 1'b1;
         else begin
            total++;
            if (s !== 3'b001) begin
               bad++;
               $display("FAIL fault_hold cyc=%0d: s=%b, want 001", i, s);
            end
         end
      end
      total++;
      if (!seen || s !== 3'b000 || pulses != 1) begin
         bad++;
         $display("FAIL fault_entry: fault=%b s=%b pulses=%0d, want 1 000 1", fault, s, pulses);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if ({s, fault, changed} !== 5'b000_1_0) begin
            bad++;
            $display("FAIL fault_stay cyc=%0d: s=%b fault=%b changed=%b, want 000 1 0", i, s, fault, changed);
         end
      end
   endtask

   task automatic test_clear();
      fault_clr = 1'b1;
      cycle();
      fault_clr = 1'b0;
      total++;
      if ({s, fault} !== 4'b000_1) begin
         bad++;
         $display("FAIL clear_illegal: s=%b fault=%b, want 000 1", s, fault);
      end
      raw_s = 3'b011;
      for (int i = 0; i < DEB + 6; i++) begin
         cycle();
         total++;
         if ({s, fault, changed} !== {m_s, m_fault, m_changed} || {s, fault} !== 4'b000_1) begin
            bad++;
            $display("FAIL clear_wait cyc=%0d: s=%b fault=%b changed=%b, want 000 1 %b", i, s, fault, changed, m_changed);
         end
      end
      fault_clr = 1'b1;
      cycle();
      fault_clr = 1'b0;
      total++;
      if ({s, fault, changed} !== 5'b011_0_1) begin
         bad++;
         $display("FAIL clear_exit: s=%b fault=%b changed=%b, want 011 0 1", s, fault, changed);
      end
      cycle();
      total++;
      if ({s, fault, changed} !== 5'b011_0_0) begin
         bad++;
         $display("FAIL clear_after: s=%b fault=%b changed=%b, want 011 0 0", s, fault, changed);
      end
   endtask

   task automatic test_reset_mid();
      int first = -1;
      bit stray = 1'b0;
      raw_s = 3'b001;
      for (int i = 0; i < 20; i++) cycle();
      total++;
      if (s !== 3'b001) begin
         bad++;
         $display("FAIL midrst_setup: s=%b, want 001", s);
      end
      raw_s = 3'b011;
      cycle();
      cycle();
      reset = 1'b1;
      fault_clr = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      fault_clr = 1'b0;
      total++;
      if ({s, fault, changed} !== 5'b000_0_0) begin
         bad++;
         $display("FAIL midrst_reset: s=%b fault=%b changed=%b, want 000 0 0", s, fault, changed);
      end
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (s === 3'b011 && first < 0) first = i;
         if (first < 0 && s !== 3'b000) stray = 1'b1;
         total++;
         if ({s, fault, changed} !== {m_s, m_fault, m_changed}) begin
            bad++;
            $display("FAIL midrst_model cyc=%0d: s=%b fault=%b changed=%b, want %b %b %b", i, s, fault, changed, m_s, m_fault, m_changed);
         end
      end
      total++;
      if (first != DEB + 3 || stray) begin
         bad++;
         $display("FAIL midrst_latency: edges=%0d stray=%0d, want %0d 0", first, stray, DEB + 3);
      end
   endtask

   task automatic test_random();
      logic [2:0] legal_codes [4];
      int cyc = 0;
      legal_codes = '{3'b000, 3'b001, 3'b011, 3'b111};
      while (cyc < 1500) begin
         int hold;
         if ($urandom_range(0, 1) == 0) raw_s = legal_codes[$urandom_range(0, 3)];
         else raw_s = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       hold = $urandom_range(1, DEB + 1);
            1:       hold = $urandom_range(DEB + 2, DEB + 12);
            default: hold = $urandom_range(FLT, FLT + 3 * DEB + 15);
         endcase
         for (int k = 0; k < hold; k++) begin
            fault_clr = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cycle();
            cyc++;
            total++;
            if ({s, fault, changed} !== {m_s, m_fault, m_changed}) begin
               bad++;
               $display("FAIL random_model cyc=%0d raw=%b: s=%b fault=%b changed=%b, want %b %b %b", cyc, raw_s, s, fault, changed, m_s, m_fault, m_changed);
            end
         end
      end
      reset = 1'b0;
      fault_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_step();
      test_fault();
      test_clear();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
